// File: rtl/decode_stage_p_pkg.sv
// Shared definitions for the ID stage: control-bundle bit map and instruction field positions.
// The listed control fields need ten bits (ALUOP is 3 wide), so the bundle is 10 bits, not 9.
package decode_pkg;
  localparam int CTRL_W        = 10;
  localparam int CTRL_ALUSRC   = 0;
  localparam int CTRL_ALUOP    = 1;  // occupies [3:1]
  localparam int CTRL_MEMWRITE = 4;
  localparam int CTRL_MEMREAD  = 5;
  localparam int CTRL_MEMTOREG = 6;
  localparam int CTRL_REGDST   = 7;
  localparam int CTRL_REGWRITE = 8;
  localparam int CTRL_IMM_ZEXT = 9;

  localparam int RS_HI  = 25, RS_LO  = 21;
  localparam int RT_HI  = 20, RT_LO  = 16;
  localparam int RD_HI  = 15, RD_LO  = 11;
  localparam int IMM_HI = 15, IMM_LO = 0;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } regsel_t;
endpackage

// File: rtl/decode_stage_p_if.sv
// IF/WB/EX-facing bundle of the decode stage; master drives the pipeline side, slave is the stage.
interface decode_stage_p_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = decode_pkg::CTRL_W
);
  logic              if_valid;
  logic [31:0]       if_instr;
  logic [CTRL_W-1:0] ctrl_in;
  logic              id_ready;
  logic              wb_we;
  logic [4:0]        wb_addr;
  logic [XLEN-1:0]   wb_data;
  logic              ex_flush;
  logic              ex_valid;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [XLEN-1:0]   ex_rs_data;
  logic [XLEN-1:0]   ex_rt_data;
  logic [XLEN-1:0]   ex_imm;
  logic [4:0]        ex_rs;
  logic [4:0]        ex_rt;
  logic [4:0]        ex_rd;
  logic [31:0]       stall_count;

  modport master (
    output if_valid, if_instr, ctrl_in, wb_we, wb_addr, wb_data, ex_flush,
    input  id_ready, ex_valid, ex_ctrl, ex_rs_data, ex_rt_data, ex_imm,
           ex_rs, ex_rt, ex_rd, stall_count
  );
  modport slave (
    input  if_valid, if_instr, ctrl_in, wb_we, wb_addr, wb_data, ex_flush,
    output id_ready, ex_valid, ex_ctrl, ex_rs_data, ex_rt_data, ex_imm,
           ex_rs, ex_rt, ex_rd, stall_count
  );
endinterface

// File: rtl/decode_stage_p_regfile.sv
// Register file: two combinational read ports, one synchronous write port, optional WB->ID bypass.
// r0 and addresses at or above NREGS read as zero and swallow writes.
module regfile_p #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr_a,
  output logic [XLEN-1:0] rdata_a,
  input  logic [4:0]      raddr_b,
  output logic [XLEN-1:0] rdata_b
);
  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  function automatic logic in_range(input logic [4:0] a);
    return (a != 5'd0) && (int'(a) < NREGS);
  endfunction

  function automatic logic [XLEN-1:0] rd(input logic [4:0] a);
    if (!in_range(a))                        return '0;
    if ((BYPASS != 0) && we && (a == waddr)) return wdata;
    return regs_q[a[AW-1:0]];
  endfunction

  always_comb begin
    regs_d = regs_q;
    if (we && in_range(waddr)) regs_d[waddr[AW-1:0]] = wdata;
  end

  always_comb begin
    rdata_a = rd(raddr_a);
    rdata_b = rd(raddr_b);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end
endmodule

// File: rtl/decode_stage_p.sv
// ID stage: register read, immediate extension, load-use stall and flush handling,
// with every result registered into the ID/EX register.
module decode_stage_p #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int CTRL_W = decode_pkg::CTRL_W,
  parameter int BYPASS = 1
) (
  input logic           clk,
  input logic           reset,
  decode_stage_p_if.slave bus
);
  import decode_pkg::*;

  regsel_t           sel;
  logic [XLEN-1:0]   rs_data, rt_data, imm;
  logic              hz, bubble;

  logic              ex_valid_q, ex_valid_d;
  logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
  logic [XLEN-1:0]   ex_rs_data_q, ex_rs_data_d;
  logic [XLEN-1:0]   ex_rt_data_q, ex_rt_data_d;
  logic [XLEN-1:0]   ex_imm_q, ex_imm_d;
  regsel_t           ex_sel_q, ex_sel_d;
  logic [31:0]       stall_count_q, stall_count_d;

  logic unused_opcode;
  assign unused_opcode = ^bus.if_instr[31:26];

  always_comb begin
    sel.rs = bus.if_instr[RS_HI:RS_LO];
    sel.rt = bus.if_instr[RT_HI:RT_LO];
    sel.rd = bus.if_instr[RD_HI:RD_LO];
    imm = bus.ctrl_in[CTRL_IMM_ZEXT]
        ? {{(XLEN-16){1'b0}}, bus.if_instr[IMM_HI:IMM_LO]}
        : {{(XLEN-16){bus.if_instr[IMM_HI]}}, bus.if_instr[IMM_HI:IMM_LO]};
  end

  regfile_p #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(BYPASS)) u_rf (
    .clk     (clk),
    .reset   (reset),
    .we      (bus.wb_we),
    .waddr   (bus.wb_addr),
    .wdata   (bus.wb_data),
    .raddr_a (sel.rs),
    .rdata_a (rs_data),
    .raddr_b (sel.rt),
    .rdata_b (rt_data)
  );

  // Both source fields are compared even for I-type ops; a spurious stall is harmless.
  always_comb begin
    hz = ex_valid_q && ex_ctrl_q[CTRL_MEMREAD] && (ex_sel_q.rt != 5'd0) && bus.if_valid &&
         ((ex_sel_q.rt == sel.rs) || (ex_sel_q.rt == sel.rt));
    bubble = bus.ex_flush || hz || !bus.if_valid;
  end

  assign bus.id_ready = reset || bus.ex_flush || !hz;

  always_comb begin
    ex_valid_d    = 1'b0;
    ex_ctrl_d     = '0;
    ex_rs_data_d  = '0;
    ex_rt_data_d  = '0;
    ex_imm_d      = '0;
    ex_sel_d      = '0;
    stall_count_d = stall_count_q;
    if (!bubble) begin
      ex_valid_d   = 1'b1;
      ex_ctrl_d    = bus.ctrl_in;
      ex_rs_data_d = rs_data;
      ex_rt_data_d = rt_data;
      ex_imm_d     = imm;
      ex_sel_d     = sel;
    end
    if (hz && !bus.ex_flush && (stall_count_q != '1)) stall_count_d = stall_count_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q    <= 1'b0;
      ex_ctrl_q     <= '0;
      ex_rs_data_q  <= '0;
      ex_rt_data_q  <= '0;
      ex_imm_q      <= '0;
      ex_sel_q      <= '0;
      stall_count_q <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_ctrl_q     <= ex_ctrl_d;
      ex_rs_data_q  <= ex_rs_data_d;
      ex_rt_data_q  <= ex_rt_data_d;
      ex_imm_q      <= ex_imm_d;
      ex_sel_q      <= ex_sel_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.ex_valid    = ex_valid_q;
  assign bus.ex_ctrl     = ex_ctrl_q;
  assign bus.ex_rs_data  = ex_rs_data_q;
  assign bus.ex_rt_data  = ex_rt_data_q;
  assign bus.ex_imm      = ex_imm_q;
  assign bus.ex_rs       = ex_sel_q.rs;
  assign bus.ex_rt       = ex_sel_q.rt;
  assign bus.ex_rd       = ex_sel_q.rd;
  assign bus.stall_count = stall_count_q;
endmodule

// File: tb/tb_decode_stage_p.sv
// Bench for decode_stage_p: two instances (bypass/32 regs and no-bypass/16 regs) share stimulus
// and are compared against an array-based model of the register file and ID/EX behaviour.
module tb_decode_stage_p;
  import decode_pkg::*;
  localparam int XLEN = 32;
  localparam int CW   = CTRL_W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic            if_valid, wb_we, ex_flush;
  logic [31:0]     if_instr;
  logic [CW-1:0]   ctrl_in;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;

  decode_stage_p_if #(.XLEN(XLEN), .CTRL_W(CW)) b0 ();
  decode_stage_p_if #(.XLEN(XLEN), .CTRL_W(CW)) b1 ();

  assign b0.if_valid = if_valid;  assign b1.if_valid = if_valid;
  assign b0.if_instr = if_instr;  assign b1.if_instr = if_instr;
  assign b0.ctrl_in  = ctrl_in;   assign b1.ctrl_in  = ctrl_in;
  assign b0.wb_we    = wb_we;     assign b1.wb_we    = wb_we;
  assign b0.wb_addr  = wb_addr;   assign b1.wb_addr  = wb_addr;
  assign b0.wb_data  = wb_data;   assign b1.wb_data  = wb_data;
  assign b0.ex_flush = ex_flush;  assign b1.ex_flush = ex_flush;

  decode_stage_p #(.XLEN(XLEN), .NREGS(32), .CTRL_W(CW), .BYPASS(1)) u0 (
    .clk(clk), .reset(reset), .bus(b0.slave));
  decode_stage_p #(.XLEN(XLEN), .NREGS(16), .CTRL_W(CW), .BYPASS(0)) u1 (
    .clk(clk), .reset(reset), .bus(b1.slave));

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [XLEN-1:0] mreg [2][32];
  int              nregs [2] = '{32, 16};
  bit              byp   [2] = '{1'b1, 1'b0};
  logic            e_valid;
  logic [CW-1:0]   e_ctrl;
  logic [XLEN-1:0] e_rsd [2];
  logic [XLEN-1:0] e_rtd [2];
  logic [XLEN-1:0] e_imm;
  logic [4:0]      e_rs, e_rt, e_rd;
  logic [31:0]     e_stall;
  bit              last_ready;

  localparam logic [CW-1:0] C_ADD = CW'((1 << CTRL_REGWRITE) | (1 << CTRL_REGDST));
  localparam logic [CW-1:0] C_LW  = CW'((1 << CTRL_MEMREAD) | (1 << CTRL_MEMTOREG) |
                                        (1 << CTRL_ALUSRC) | (1 << CTRL_REGWRITE));
  localparam logic [CW-1:0] C_ZX  = CW'((1 << CTRL_IMM_ZEXT) | (1 << CTRL_ALUSRC));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int rs, input int rt, input logic [15:0] imm);
    return {6'd0, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [XLEN-1:0] mread(input int i, input logic [4:0] a);
    if (a == 0 || int'(a) >= nregs[i]) return '0;
    if (byp[i] && wb_we && a == wb_addr) return wb_data;
    return mreg[i][a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < 32; r++) mreg[i][r] = '0;
      e_rsd[i] = '0; e_rtd[i] = '0;
    end
    e_valid = 0; e_ctrl = '0; e_imm = '0; e_rs = 0; e_rt = 0; e_rd = 0; e_stall = 0;
    last_ready = 1;
  endtask

  task automatic chk_outs();
    chk("ex_valid0", b0.ex_valid, e_valid);     chk("ex_valid1", b1.ex_valid, e_valid);
    chk("ex_ctrl0", b0.ex_ctrl, e_ctrl);        chk("ex_ctrl1", b1.ex_ctrl, e_ctrl);
    chk("ex_rs_data0", b0.ex_rs_data, e_rsd[0]); chk("ex_rs_data1", b1.ex_rs_data, e_rsd[1]);
    chk("ex_rt_data0", b0.ex_rt_data, e_rtd[0]); chk("ex_rt_data1", b1.ex_rt_data, e_rtd[1]);
    chk("ex_imm0", b0.ex_imm, e_imm);           chk("ex_imm1", b1.ex_imm, e_imm);
    chk("ex_rs0", b0.ex_rs, e_rs);              chk("ex_rs1", b1.ex_rs, e_rs);
    chk("ex_rt0", b0.ex_rt, e_rt);              chk("ex_rt1", b1.ex_rt, e_rt);
    chk("ex_rd0", b0.ex_rd, e_rd);              chk("ex_rd1", b1.ex_rd, e_rd);
    chk("stall0", b0.stall_count, e_stall);     chk("stall1", b1.stall_count, e_stall);
  endtask

  // Inputs are already driven; checks id_ready, advances one edge, checks the ID/EX outputs.
  task automatic cycle();
    bit hz, bub;
    logic [XLEN-1:0] nrs [2];
    logic [XLEN-1:0] nrt [2];
    logic [4:0] rs, rt;
    #1;
    rs = if_instr[25:21];
    rt = if_instr[20:16];
    hz = e_valid && e_ctrl[CTRL_MEMREAD] && e_rt != 0 && if_valid && (e_rt == rs || e_rt == rt);
    chk("id_ready0", b0.id_ready, !hz || ex_flush);
    chk("id_ready1", b1.id_ready, !hz || ex_flush);
    bub = ex_flush || hz || !if_valid;
    for (int i = 0; i < 2; i++) begin
      nrs[i] = mread(i, rs);
      nrt[i] = mread(i, rt);
    end
    for (int i = 0; i < 2; i++)
      if (wb_we && wb_addr != 0 && int'(wb_addr) < nregs[i]) mreg[i][wb_addr] = wb_data;
    if (hz && !ex_flush && e_stall != 32'hFFFF_FFFF) e_stall = e_stall + 1;
    e_valid = !bub;
    e_ctrl  = bub ? '0 : ctrl_in;
    for (int i = 0; i < 2; i++) begin
      e_rsd[i] = bub ? '0 : nrs[i];
      e_rtd[i] = bub ? '0 : nrt[i];
    end
    e_imm = bub ? '0 : (ctrl_in[CTRL_IMM_ZEXT] ? {16'd0, if_instr[15:0]}
                                               : {{16{if_instr[15]}}, if_instr[15:0]});
    e_rs = bub ? '0 : rs;
    e_rt = bub ? '0 : rt;
    e_rd = bub ? '0 : if_instr[15:11];
    last_ready = !hz || ex_flush;
    @(posedge clk); #1;
    chk_outs();
  endtask

  task automatic idle();
    if_valid = 0; if_instr = '0; ctrl_in = '0; wb_we = 0; wb_addr = 0; wb_data = '0; ex_flush = 0;
  endtask

  initial begin
    reset = 1;
    idle();
    model_reset();
    #12;
    chk("rst_ready", b0.id_ready, 1'b1);
    chk("rst_valid", b0.ex_valid, 1'b0);
    chk("rst_stall", b1.stall_count, 32'd0);
    reset = 0;
    @(posedge clk); #1;

    // write r5 then read it through add r1,r5,r0
    wb_we = 1; wb_addr = 5; wb_data = 32'hDEAD_BEEF;
    cycle();
    idle(); if_valid = 1; if_instr = mk(5, 0, 16'h0820); ctrl_in = C_ADD;
    cycle();
    chk("wr_rd_rs", b0.ex_rs_data, 32'hDEAD_BEEF);
    chk("wr_rd_rt", b0.ex_rt_data, 32'd0);
    chk("wr_rd_vld", b0.ex_valid, 1'b1);

    // same-cycle bypass on r7
    idle(); wb_we = 1; wb_addr = 7; wb_data = 32'h55;
    cycle();
    if_valid = 1; if_instr = mk(7, 0, 16'h0); ctrl_in = C_ADD; wb_data = 32'h1234;
    cycle();
    chk("byp_on", b0.ex_rs_data, 32'h1234);
    chk("byp_off", b1.ex_rs_data, 32'h55);

    // load-use: lw r3,4(r2) ; add r4,r3,r1
    idle(); if_valid = 1; if_instr = mk(2, 3, 16'd4); ctrl_in = C_LW;
    cycle();
    if_instr = mk(3, 1, 16'h2020); ctrl_in = C_ADD;
    cycle();
    chk("lu_ready", last_ready, 1'b0);
    chk("lu_valid", b0.ex_valid, 1'b0);
    chk("lu_ctrl", b0.ex_ctrl, '0);
    chk("lu_stall", b0.stall_count, 32'd1);
    cycle();
    chk("lu_issue", b0.ex_valid, 1'b1);

    // flush beats hazard
    if_instr = mk(2, 3, 16'd4); ctrl_in = C_LW;
    cycle();
    if_instr = mk(3, 1, 16'h2020); ctrl_in = C_ADD; ex_flush = 1;
    #1;
    chk("fl_ready", b0.id_ready, 1'b1);
    cycle();
    chk("fl_valid", b0.ex_valid, 1'b0);
    chk("fl_stall", b0.stall_count, 32'd1);

    // r0 write ignored, immediates, write above NREGS of the small instance
    idle(); wb_we = 1; wb_addr = 0; wb_data = 32'hFFFF;
    cycle();
    idle(); wb_we = 1; wb_addr = 20; wb_data = 32'hABCD;
    if_valid = 1; if_instr = mk(0, 0, 16'h8000); ctrl_in = C_ADD;
    cycle();
    chk("r0_read", b0.ex_rs_data, 32'd0);
    chk("imm_sext", b0.ex_imm, 32'hFFFF_8000);
    idle(); if_valid = 1; if_instr = mk(20, 0, 16'h8000); ctrl_in = C_ZX;
    cycle();
    chk("imm_zext", b0.ex_imm, 32'h0000_8000);
    chk("hi_addr0", b0.ex_rs_data, 32'hABCD);
    chk("hi_addr1", b1.ex_rs_data, 32'd0);

    // randomized traffic; IF holds its instruction while stalled
    for (int n = 0; n < 400; n++) begin
      if (last_ready || !if_valid) begin
        if_valid = ($urandom_range(0, 9) < 8);
        if_instr = mk($urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom));
        ctrl_in  = CW'($urandom);
        if ($urandom_range(0, 2) == 0) ctrl_in[CTRL_MEMREAD] = 1'b1;
      end
      wb_we    = $urandom_range(0, 1);
      wb_addr  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      wb_data  = $urandom;
      ex_flush = ($urandom_range(0, 9) == 0);
      cycle();
    end

    // reset in the middle of a stall
    idle(); if_valid = 1; if_instr = mk(2, 3, 16'd4); ctrl_in = C_LW;
    cycle();
    if_instr = mk(3, 1, 16'h2020); ctrl_in = C_ADD;
    #1;
    chk("mr_pre", b0.id_ready, 1'b0);
    reset = 1;
    #1;
    chk("mr_ready", b0.id_ready, 1'b1);
    chk("mr_valid", b0.ex_valid, 1'b0);
    chk("mr_stall", b0.stall_count, 32'd0);
    model_reset();
    reset = 0;
    @(posedge clk); #1;
    idle(); if_valid = 1; if_instr = mk(5, 7, 16'h0); ctrl_in = C_ADD;
    cycle();
    chk("mr_r5", b0.ex_rs_data, 32'd0);
    chk("mr_r7", b0.ex_rt_data, 32'd0);
    chk("mr_valid2", b0.ex_valid, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
